// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// legal branch-resolve stages and per-stage indices into the enable vector.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalt    = 2'd2
  } state_e;

  // Stage in which branches resolve; decides how many younger stages get squashed.
  localparam int unsigned BranchStageEx  = 2;
  localparam int unsigned BranchStageMem = 3;

  // Index of each pipeline register in the write-enable vector.
  localparam int unsigned StagePc    = 0;
  localparam int unsigned StageIfId  = 1;
  localparam int unsigned StageIdEx  = 2;
  localparam int unsigned StageExMem = 3;
  localparam int unsigned StageMemWb = 4;
  localparam int unsigned NumStages  = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard comparator: a load in EX whose destination is read by the
// instruction in ID. x0 never creates a dependency.
module pipe_hazard_ctrl_load_use_detect #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  memread,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  output logic                  hazard
);

  // Flag a dependency only on sources the ID instruction actually reads.
  always_comb begin
    hazard = memread & (rd != '0) &
             ((use_rs1 & (rs1 == rd)) | (use_rs2 & (rs2 == rd)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage in-order pipeline. Priority in RUN is
// memory wait > branch squash > load-use. A memory wait longer than
// MEM_TIMEOUT cycles parks the controller in HALT until reset.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned BRANCH_STAGE   = 3,
  parameter int unsigned MEM_TIMEOUT    = 64,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_ex_memread,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_rd,
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rs2,
  input  logic                      if_id_use_rs1,
  input  logic                      if_id_use_rs2,
  input  logic                      branch_taken,
  input  logic                      data_req,
  input  logic                      data_ack,
  output logic                      pc_we,
  output logic                      if_id_we,
  output logic                      id_ex_we,
  output logic                      ex_mem_we,
  output logic                      mem_wb_we,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      ex_mem_flush,
  output logic                      mem_wb_flush,
  output logic                      pc_redirect,
  output logic                      halted,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam int unsigned       WaitW    = $clog2(MEM_TIMEOUT);
  localparam logic [WaitW-1:0]  WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [WaitW-1:0]       wait_q, wait_d;
  logic                   halted_q;
  logic [CNT_WIDTH-1:0]   stall_q, flush_q;
  logic [NumStages-1:0]   we;
  logic                   load_use;
  logic                   mem_hold;

  pipe_hazard_ctrl_load_use_detect #(
    .ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_load_use (
    .memread (id_ex_memread),
    .rd      (id_ex_rd),
    .rs1     (if_id_rs1),
    .rs2     (if_id_rs2),
    .use_rs1 (if_id_use_rs1),
    .use_rs2 (if_id_use_rs2),
    .hazard  (load_use)
  );

  // Once waiting, only the ack releases the freeze; a zero-cycle ack never stalls.
  assign mem_hold = (state_q == StMemWait) ? ~data_ack : (data_req & ~data_ack);

  // State, wait-counter and sticky halt registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRun;
      wait_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      halted_q <= halted_q | (state_d == StHalt);
    end
  end

  // Next-state: enter MEM_WAIT on a stall, leave on ack, halt on timeout.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      StRun: begin
        if (mem_hold) begin
          state_d = StMemWait;
          wait_d  = WaitW'(1);
        end
      end
      StMemWait: begin
        if (data_ack) begin
          state_d = StRun;
          wait_d  = '0;
        end else if (wait_q == WaitLast) begin
          state_d = StHalt;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // Output decode: stage enables, bubble strobes and PC redirect.
  always_comb begin
    we           = '0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    pc_redirect  = 1'b0;
    if (!rst) begin
      case (state_q)
        StRun, StMemWait: begin
          if (mem_hold) begin
            // Freeze upstream; drain a bubble into WB so the stalled access isn't retired twice.
            we[StageMemWb] = 1'b1;
            mem_wb_flush   = 1'b1;
          end else if (branch_taken) begin
            we           = '1;
            pc_redirect  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = (BRANCH_STAGE == BranchStageMem);
          end else if (load_use) begin
            we             = '1;
            we[StagePc]    = 1'b0;
            we[StageIfId]  = 1'b0;
            id_ex_flush    = 1'b1;
          end else begin
            we = '1;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating performance counters; HALT cycles are not counted as stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!we[StagePc] && (state_q != StHalt) && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_WIDTH'(1);
      end
      if (pc_redirect && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_WIDTH'(1);
      end
    end
  end

  assign pc_we     = we[StagePc];
  assign if_id_we  = we[StageIfId];
  assign id_ex_we  = we[StageIdEx];
  assign ex_mem_we = we[StageExMem];
  assign mem_wb_we = we[StageMemWb];
  assign halted    = halted_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Two instances share stimulus: A resolves branches
// in MEM with a short timeout and 4-bit counters, B resolves in EX with defaults.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_ex_memread;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic       if_id_use_rs1, if_id_use_rs2, branch_taken, data_req, data_ack;

  logic a_pc_we, a_if_id_we, a_id_ex_we, a_ex_mem_we, a_mem_wb_we;
  logic a_if_id_flush, a_id_ex_flush, a_ex_mem_flush, a_mem_wb_flush, a_pc_redirect, a_halted;
  logic [3:0] a_stall_cnt, a_flush_cnt;
  logic b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we, b_mem_wb_we;
  logic b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_mem_wb_flush, b_pc_redirect, b_halted;
  logic [15:0] b_stall_cnt, b_flush_cnt;
  logic [9:0] a_ctrl, b_ctrl;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_ADDR_WIDTH(5), .BRANCH_STAGE(3), .MEM_TIMEOUT(4), .CNT_WIDTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1),
    .if_id_use_rs2(if_id_use_rs2), .branch_taken(branch_taken), .data_req(data_req),
    .data_ack(data_ack), .pc_we(a_pc_we), .if_id_we(a_if_id_we), .id_ex_we(a_id_ex_we),
    .ex_mem_we(a_ex_mem_we), .mem_wb_we(a_mem_wb_we), .if_id_flush(a_if_id_flush),
    .id_ex_flush(a_id_ex_flush), .ex_mem_flush(a_ex_mem_flush),
    .mem_wb_flush(a_mem_wb_flush), .pc_redirect(a_pc_redirect), .halted(a_halted),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipe_hazard_ctrl #(
    .REG_ADDR_WIDTH(5), .BRANCH_STAGE(2), .MEM_TIMEOUT(64), .CNT_WIDTH(16)
  ) dut_b (
    .clk(clk), .rst(rst), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1),
    .if_id_use_rs2(if_id_use_rs2), .branch_taken(branch_taken), .data_req(data_req),
    .data_ack(data_ack), .pc_we(b_pc_we), .if_id_we(b_if_id_we), .id_ex_we(b_id_ex_we),
    .ex_mem_we(b_ex_mem_we), .mem_wb_we(b_mem_wb_we), .if_id_flush(b_if_id_flush),
    .id_ex_flush(b_id_ex_flush), .ex_mem_flush(b_ex_mem_flush),
    .mem_wb_flush(b_mem_wb_flush), .pc_redirect(b_pc_redirect), .halted(b_halted),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem, mem_wb flushes, redirect}
  assign a_ctrl = {a_pc_we, a_if_id_we, a_id_ex_we, a_ex_mem_we, a_mem_wb_we,
                   a_if_id_flush, a_id_ex_flush, a_ex_mem_flush, a_mem_wb_flush, a_pc_redirect};
  assign b_ctrl = {b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we, b_mem_wb_we,
                   b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_mem_wb_flush, b_pc_redirect};

  int passed = 0;
  int total  = 0;

  // Reference model, one slot per instance.
  int cfg_bs[2]  = '{3, 2};
  int cfg_to[2]  = '{4, 64};
  int cfg_max[2] = '{15, 65535};
  bit m_halt[2];
  bit m_wait[2];     // a memory access is outstanding and the pipe is frozen on it
  int m_wn[2];       // cycles frozen so far on the outstanding access
  int m_stall[2];
  int m_flush[2];
  logic [9:0] exp_ctrl[2];

  function automatic bit model_hold(input int i);
    return m_wait[i] ? !data_ack : (data_req && !data_ack);
  endfunction

  function automatic logic [9:0] model_ctrl(input int i);
    bit lu;
    if (m_halt[i]) return 10'd0;
    if (model_hold(i)) return 10'b00001_0001_0;
    if (branch_taken) return {5'b11111, 2'b11, (cfg_bs[i] == 3), 2'b01};
    lu = id_ex_memread && (id_ex_rd != 0) &&
         ((if_id_use_rs1 && if_id_rs1 == id_ex_rd) || (if_id_use_rs2 && if_id_rs2 == id_ex_rd));
    if (lu) return 10'b00111_0100_0;
    return 10'b11111_0000_0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_halt[i] = 0; m_wait[i] = 0; m_wn[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic [9:0] c;
      c = model_ctrl(i);
      if (!m_halt[i]) begin
        if (!c[9] && m_stall[i] < cfg_max[i]) m_stall[i]++;
        if (c[0] && m_flush[i] < cfg_max[i]) m_flush[i]++;
        if (model_hold(i)) begin
          if (!m_wait[i]) begin
            m_wait[i] = 1; m_wn[i] = 1;
          end else if (m_wn[i] == cfg_to[i] - 1) begin
            m_halt[i] = 1;
          end else begin
            m_wn[i]++;
          end
        end else begin
          m_wait[i] = 0; m_wn[i] = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic u1, input logic u2,
                       input logic br, input logic req, input logic ack);
    @(negedge clk);
    id_ex_memread = mr; id_ex_rd = rd; if_id_rs1 = r1; if_id_rs2 = r2;
    if_id_use_rs1 = u1; if_id_use_rs2 = u2; branch_taken = br; data_req = req; data_ack = ack;
    #1;
    exp_ctrl[0] = model_ctrl(0);
    exp_ctrl[1] = model_ctrl(1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asserts reset mid-cycle, away from any edge, and leaves it high for checking.
  task automatic assert_reset();
    @(posedge clk);
    model_edge();
    #3;
    id_ex_memread = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    if_id_use_rs1 = 0; if_id_use_rs2 = 0; branch_taken = 0; data_req = 0; data_ack = 0;
    rst = 1'b1;
    model_clear();
    #1;
  endtask

  task automatic release_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_ex_memread = 1; id_ex_rd = 5; if_id_rs1 = 5; if_id_rs2 = 0;
    if_id_use_rs1 = 1; if_id_use_rs2 = 0; branch_taken = 1; data_req = 1; data_ack = 0;
    model_clear();
    #12;
    total++; if ({a_ctrl, b_ctrl} !== 20'd0)
      $display("FAIL reset_ctrl got %b %b want all zero", a_ctrl, b_ctrl); else passed++;
    total++; if ({a_halted, b_halted} !== 2'b00)
      $display("FAIL reset_halted got %b%b want 00", a_halted, b_halted); else passed++;
    total++; if ({a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt} !== 40'd0)
      $display("FAIL reset_counters got %h %h %h %h want 0", a_stall_cnt, a_flush_cnt,
               b_stall_cnt, b_flush_cnt); else passed++;
    #4;
    branch_taken = 0; data_req = 0; id_ex_memread = 0;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (a_ctrl !== 10'b11111_0000_0 || b_ctrl !== exp_ctrl[1])
      $display("FAIL reset_idle got %b %b want %b", a_ctrl, b_ctrl, 10'b11111_0000_0); else passed++;
    tick();
  endtask

  task automatic test_load_use();
    assert_reset(); release_reset();
    // lw x5 in EX, add x6,x5,x7 in ID
    drive(1, 5, 5, 7, 1, 1, 0, 0, 0);
    total++; if (a_ctrl !== exp_ctrl[0] || a_ctrl !== 10'b00111_0100_0)
      $display("FAIL lu_ctrl_a got %b want %b", a_ctrl, exp_ctrl[0]); else passed++;
    total++; if (b_ctrl !== exp_ctrl[1])
      $display("FAIL lu_ctrl_b got %b want %b", b_ctrl, exp_ctrl[1]); else passed++;
    tick();
    total++; if (a_stall_cnt !== 4'd1 || b_stall_cnt !== 16'd1)
      $display("FAIL lu_stall_cnt got %0d %0d want 1", a_stall_cnt, b_stall_cnt); else passed++;
    drive(0, 5, 6, 5, 1, 1, 0, 0, 0);
    total++; if (a_ctrl !== 10'b11111_0000_0 || b_ctrl !== exp_ctrl[1])
      $display("FAIL lu_release got %b %b want %b", a_ctrl, b_ctrl, exp_ctrl[1]); else passed++;
    tick();
  endtask

  task automatic test_no_stall();
    assert_reset(); release_reset();
    drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
    total++; if (a_ctrl !== exp_ctrl[0] || a_pc_we !== 1'b1)
      $display("FAIL nostall_x0 got %b want %b", a_ctrl, exp_ctrl[0]); else passed++;
    tick();
    drive(1, 5, 5, 5, 0, 0, 0, 0, 0);
    total++; if (a_ctrl !== exp_ctrl[0] || b_pc_we !== 1'b1)
      $display("FAIL nostall_unused got %b want %b", a_ctrl, exp_ctrl[0]); else passed++;
    tick();
    total++; if (a_stall_cnt !== 4'd0 || b_stall_cnt !== 16'd0)
      $display("FAIL nostall_cnt got %0d %0d want 0", a_stall_cnt, b_stall_cnt); else passed++;
  endtask

  task automatic test_branch();
    assert_reset(); release_reset();
    // Taken branch also suppresses the load-use that is present in the same cycle.
    drive(1, 5, 5, 0, 1, 0, 1, 0, 0);
    total++; if (a_ctrl !== 10'b11111_1110_1 || a_ctrl !== exp_ctrl[0])
      $display("FAIL branch_mem got %b want %b", a_ctrl, exp_ctrl[0]); else passed++;
    total++; if (b_ctrl !== 10'b11111_1100_1 || b_ctrl !== exp_ctrl[1])
      $display("FAIL branch_ex got %b want %b", b_ctrl, exp_ctrl[1]); else passed++;
    tick();
    total++; if (a_flush_cnt !== 4'd1 || b_flush_cnt !== 16'd1 || a_stall_cnt !== 4'd0)
      $display("FAIL branch_cnt got %0d %0d %0d want 1 1 0", a_flush_cnt, b_flush_cnt,
               a_stall_cnt); else passed++;
  endtask

  task automatic test_mem_wait_branch();
    assert_reset(); release_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
      total++; if (a_ctrl !== 10'b00001_0001_0 || b_ctrl !== exp_ctrl[1])
        $display("FAIL memwait_freeze%0d got %b %b want %b", k, a_ctrl, b_ctrl,
                 exp_ctrl[1]); else passed++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    total++; if (a_ctrl !== 10'b11111_1110_1 || b_ctrl !== exp_ctrl[1])
      $display("FAIL memwait_ack got %b %b want %b", a_ctrl, b_ctrl, exp_ctrl[1]); else passed++;
    tick();
    total++; if (a_stall_cnt !== 4'd3 || b_stall_cnt !== 16'd3 || a_flush_cnt !== 4'd1)
      $display("FAIL memwait_cnt got %0d %0d %0d want 3 3 1", a_stall_cnt, b_stall_cnt,
               a_flush_cnt); else passed++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (a_ctrl !== 10'b11111_0000_0)
      $display("FAIL memwait_resume got %b want %b", a_ctrl, 10'b11111_0000_0); else passed++;
    tick();
  endtask

  task automatic test_timeout();
    assert_reset(); release_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      total++; if (a_halted !== 1'(m_halt[0]))
        $display("FAIL timeout_halt%0d got %b want %b", k, a_halted, m_halt[0]); else passed++;
    end
    total++; if (a_halted !== 1'b1 || b_halted !== 1'b0)
      $display("FAIL timeout_sticky got %b %b want 1 0", a_halted, b_halted); else passed++;
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    total++; if (a_ctrl !== 10'd0 || b_ctrl !== exp_ctrl[1])
      $display("FAIL timeout_frozen got %b %b want %b %b", a_ctrl, b_ctrl, 10'd0,
               exp_ctrl[1]); else passed++;
    tick();
    total++; if (a_stall_cnt !== 4'd4 || a_halted !== 1'b1)
      $display("FAIL timeout_cnt got %0d %b want 4 1", a_stall_cnt, a_halted); else passed++;
    assert_reset();
    total++; if (a_halted !== 1'b0 || a_stall_cnt !== 4'd0 || a_ctrl !== 10'd0)
      $display("FAIL timeout_async_rst got %b %0d %b want 0 0 0", a_halted, a_stall_cnt,
               a_ctrl); else passed++;
    release_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (a_ctrl !== 10'b11111_0000_0 || b_ctrl !== 10'b11111_0000_0)
      $display("FAIL timeout_run got %b %b want %b", a_ctrl, b_ctrl, 10'b11111_0000_0); else passed++;
    tick();
  endtask

  task automatic test_saturation();
    assert_reset(); release_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1, 3, 3, 0, 1, 0, 0, 0, 0);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick();
    end
    total++; if (a_stall_cnt !== 4'd15 || a_flush_cnt !== 4'd15)
      $display("FAIL sat_a got %0d %0d want 15 15", a_stall_cnt, a_flush_cnt); else passed++;
    total++; if (b_stall_cnt !== 16'd20 || b_flush_cnt !== 16'd20)
      $display("FAIL sat_b got %0d %0d want 20 20", b_stall_cnt, b_flush_cnt); else passed++;
  endtask

  task automatic test_random();
    assert_reset(); release_reset();
    for (int k = 0; k < 600; k++) begin
      if (m_halt[0] && $urandom_range(0, 3) == 0) begin
        assert_reset(); release_reset();
      end
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)));
      total++; if (a_ctrl !== exp_ctrl[0])
        $display("FAIL rnd_ctrl_a@%0d got %b want %b", k, a_ctrl, exp_ctrl[0]); else passed++;
      total++; if (b_ctrl !== exp_ctrl[1])
        $display("FAIL rnd_ctrl_b@%0d got %b want %b", k, b_ctrl, exp_ctrl[1]); else passed++;
      tick();
      total++; if (a_stall_cnt !== m_stall[0][3:0] || a_flush_cnt !== m_flush[0][3:0])
        $display("FAIL rnd_cnt_a@%0d got %0d %0d want %0d %0d", k, a_stall_cnt, a_flush_cnt,
                 m_stall[0], m_flush[0]); else passed++;
      total++; if (b_stall_cnt !== m_stall[1][15:0] || b_flush_cnt !== m_flush[1][15:0])
        $display("FAIL rnd_cnt_b@%0d got %0d %0d want %0d %0d", k, b_stall_cnt, b_flush_cnt,
                 m_stall[1], m_flush[1]); else passed++;
      total++; if ({a_halted, b_halted} !== {1'(m_halt[0]), 1'(m_halt[1])})
        $display("FAIL rnd_halted@%0d got %b%b want %b%b", k, a_halted, b_halted,
                 m_halt[0], m_halt[1]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_wait_branch();
    test_timeout();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
